// File: rtl/beep_arbiter.sv
// Two-requester beep/tone arbiter: fixed priority (alarm over melody) at note boundaries,
// plays each note for its duration, then holds a silent gap before the next grant.
module beep_arbiter #(
  parameter logic [23:0] GAP_CYC    = 24'd500_000,
  parameter logic [15:0] MIN_PERIOD = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_period,
  input  logic [23:0] req0_dur,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_period,
  input  logic [23:0] req1_dur,
  output logic        req1_ready,
  input  logic        abort,
  output logic        tone_en,
  output logic [15:0] tone_period,
  output logic [15:0] tone_duty,
  output logic        owner,
  output logic        busy,
  output logic        note_done
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic [15:0] period_q;
  logic        tone_en_q;
  logic        owner_q;
  logic        note_done_q;

  logic        grant;
  logic        xfer;
  logic [15:0] sel_period;
  logic [15:0] clamped_period;
  logic [23:0] sel_dur;
  logic [23:0] play_load;

  // Handshake is decided in the IDLE cycle itself; reset and abort both veto it.
  always_comb begin
    grant          = ~req0_valid;
    xfer           = (state_q == StIdle) && !rst && !abort && (req0_valid || req1_valid);
    req0_ready     = xfer && req0_valid;
    req1_ready     = xfer && !req0_valid;
    sel_period     = grant ? req1_period : req0_period;
    sel_dur        = grant ? req1_dur : req0_dur;
    clamped_period = ((sel_period != 16'd0) && (sel_period < MIN_PERIOD)) ? MIN_PERIOD
                                                                           : sel_period;
    play_load      = (sel_dur == 24'd0) ? 24'd0 : sel_dur - 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 24'd0;
      period_q    <= 16'd0;
      tone_en_q   <= 1'b0;
      owner_q     <= 1'b0;
      note_done_q <= 1'b0;
    end else if (abort) begin
      state_q     <= StIdle;
      cnt_q       <= 24'd0;
      tone_en_q   <= 1'b0;
      note_done_q <= 1'b0;
    end else begin
      note_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            state_q   <= StPlay;
            owner_q   <= grant;
            period_q  <= clamped_period;
            cnt_q     <= play_load;
            tone_en_q <= (clamped_period != 16'd0);
          end
        end
        StPlay: begin
          if (cnt_q == 24'd0) begin
            tone_en_q <= 1'b0;
            if (GAP_CYC == 24'd0) begin
              state_q     <= StIdle;
              note_done_q <= 1'b1;
            end else begin
              state_q <= StGap;
              cnt_q   <= GAP_CYC - 24'd1;
            end
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        StGap: begin
          if (cnt_q == 24'd0) begin
            state_q     <= StIdle;
            note_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tone_en     = tone_en_q;
  assign tone_period = period_q;
  assign tone_duty   = {1'b0, period_q[15:1]};
  assign owner       = owner_q;
  assign busy        = (state_q == StPlay) || (state_q == StGap);
  assign note_done   = note_done_q;

endmodule

// File: tb/tb_beep_arbiter.sv
// Scoreboard bench for beep_arbiter: stimulus pushes predicted notes, a monitor checks
// every cycle of each note from its handshake through gap and completion.
module tb_beep_arbiter;

  localparam int GAP  = 4;
  localparam int MINP = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, abort = 1'b0;
  logic [15:0] req0_period = '0, req1_period = '0;
  logic [23:0] req0_dur = '0, req1_dur = '0;
  logic        req0_ready, req1_ready, tone_en, owner, busy, note_done;
  logic [15:0] tone_period, tone_duty;

  beep_arbiter #(.GAP_CYC(24'd4), .MIN_PERIOD(16'd1000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_period(req0_period), .req0_dur(req0_dur),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_period(req1_period), .req1_dur(req1_dur),
    .req1_ready(req1_ready),
    .abort(abort), .tone_en(tone_en), .tone_period(tone_period), .tone_duty(tone_duty),
    .owner(owner), .busy(busy), .note_done(note_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 normal, 1 abort in PLAY cycle 'at', 2 reset in GAP cycle 'at'
  typedef struct {
    logic        owner;
    logic [15:0] period;
    int          dur;
    bit          b2b;
    int          kind;
    int          at;
  } note_t;

  note_t sb[$];
  int n_checks = 0, n_fail = 0;
  int prev_xfer = 0, prev_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] eff_period(input logic [15:0] p);
    if (p == 16'd0) return 16'd0;
    if (int'(p) < MINP) return 16'(MINP);
    return p;
  endfunction

  function automatic note_t mk(input logic o, input logic [15:0] p, input logic [23:0] d,
                               input bit b2b, input int kind, input int at);
    note_t n;
    n.owner = o; n.period = eff_period(p); n.dur = (d == 0) ? 1 : int'(d);
    n.b2b = b2b; n.kind = kind; n.at = at;
    return n;
  endfunction

  function automatic logic [15:0] rnd_period();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'($urandom_range(1, 999));
      default: return 16'($urandom_range(1000, 65535));
    endcase
  endfunction

  // Monitor: called at the negedge of the handshake cycle.
  task automatic check_note(input note_t e, output bit at_done);
    int plays, gaps;
    at_done = 0;
    chk("ready_select", 32'({req1_ready, req0_ready}), e.owner ? 32'd2 : 32'd1);
    if (e.b2b) chk("b2b_pitch", 32'(cyc - prev_xfer), 32'(prev_len + GAP + 1));
    prev_xfer = cyc;
    prev_len  = e.dur;
    plays = (e.kind == 1) ? e.at : e.dur;
    for (int i = 0; i < plays; i++) begin
      @(negedge clk);
      chk("play_tone_en", 32'(tone_en), 32'(e.period != 0));
      chk("play_period", 32'(tone_period), 32'(e.period));
      chk("play_duty", 32'(tone_duty), 32'(e.period / 2));
      chk("play_owner", 32'(owner), 32'(e.owner));
      chk("play_busy_done", 32'({busy, note_done}), 32'd2);
      chk("play_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
    end
    if (e.kind == 1) begin
      @(negedge clk);
      chk("abort_quiet", 32'({tone_en, busy, note_done}), 32'd0);
      chk("abort_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
      chk("abort_no_done", 32'(note_done), 32'd0);
      return;
    end
    gaps = (e.kind == 2) ? e.at : GAP;
    for (int j = 0; j < gaps; j++) begin
      @(negedge clk);
      chk("gap_tone_en", 32'(tone_en), 32'd0);
      chk("gap_period_hold", 32'(tone_period), 32'(e.period));
      chk("gap_busy_done", 32'({busy, note_done}), 32'd2);
      chk("gap_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
    end
    if (e.kind == 2) begin
      @(negedge clk);
      chk("rst_flags", 32'({tone_en, owner, busy, note_done}), 32'd0);
      chk("rst_period_duty", {tone_period, tone_duty}, 32'd0);
      chk("rst_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
      return;
    end
    @(negedge clk);
    chk("done_pulse", 32'({note_done, busy, tone_en}), 32'd4);
    chk("done_period_hold", 32'(tone_period), 32'(e.period));
    chk("done_owner_hold", 32'(owner), 32'(e.owner));
    at_done = 1;
  endtask

  initial begin : monitor
    note_t e;
    bit at_done, was_done;
    at_done = 0;
    while (rst) @(negedge clk);
    forever begin
      if (!at_done) @(negedge clk);
      was_done = at_done;
      at_done  = 0;
      if (req0_ready || req1_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready at cycle %0d: got ready=%b%b expected none",
                   cyc, req1_ready, req0_ready);
        end else begin
          e = sb.pop_front();
          check_note(e, at_done);
        end
      end else if (!was_done) begin
        chk("idle_quiet", 32'({note_done, busy}), 32'd0);
      end
    end
  end

  task automatic send(input bit who, input logic [15:0] p, input logic [23:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    if (who) begin req1_valid = 1; req1_period = p; req1_dur = d; end
    else     begin req0_valid = 1; req0_period = p; req0_dur = d; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((who ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    // Scramble the held fields: they must not affect the latched note.
    if (who) begin req1_valid = 0; req1_period = 16'($urandom); req1_dur = 24'($urandom); end
    else     begin req0_valid = 0; req0_period = 16'($urandom); req0_dur = 24'($urandom); end
    chk("xfer_handshake", 32'(ok), 32'd1);
  endtask

  task automatic settle(input logic [23:0] d);
    repeat (((d == 0) ? 1 : int'(d)) + GAP + 4) @(posedge clk);
  endtask

  task automatic txn_single(input bit who, input logic [15:0] p, input logic [23:0] d);
    sb.push_back(mk(who, p, d, 0, 0, 0));
    send(who, p, d);
    settle(d);
  endtask

  task automatic txn_both(input logic [15:0] p0, input logic [23:0] d0,
                          input logic [15:0] p1, input logic [23:0] d1);
    sb.push_back(mk(1'b0, p0, d0, 0, 0, 0));
    sb.push_back(mk(1'b1, p1, d1, 1, 0, 0));
    fork
      send(1'b0, p0, d0);
      send(1'b1, p1, d1);
    join
    settle(d1);
  endtask

  task automatic txn_mid(input logic [15:0] p1, input logic [23:0] d1, input int k,
                         input logic [15:0] p0, input logic [23:0] d0);
    sb.push_back(mk(1'b1, p1, d1, 0, 0, 0));
    sb.push_back(mk(1'b0, p0, d0, 1, 0, 0));
    fork
      send(1'b1, p1, d1);
      begin
        repeat (k) @(posedge clk);
        send(1'b0, p0, d0);
      end
    join
    settle(d0);
  endtask

  task automatic txn_abort(input bit who, input logic [15:0] p, input logic [23:0] d,
                           input int c);
    sb.push_back(mk(who, p, d, 0, 1, c));
    send(who, p, d);
    repeat (c - 1) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic txn_rstgap(input bit who, input logic [15:0] p, input logic [23:0] d,
                            input int g);
    int deff;
    deff = (d == 0) ? 1 : int'(d);
    sb.push_back(mk(who, p, d, 0, 2, g));
    send(who, p, d);
    repeat (deff + g - 1) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin : stimulus
    int kind, d, c;
    req0_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blocks_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("reset_flags", 32'({tone_en, owner, busy, note_done}), 32'd0);
    chk("reset_period_duty", {tone_period, tone_duty}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    req0_valid = 0;
    repeat (2) @(posedge clk);

    txn_single(1'b1, 16'd28400, 24'd10);
    txn_both(16'd2000, 24'd8, 16'd3000, 24'd5);
    txn_mid(16'd5000, 24'd20, 5, 16'd1500, 24'd3);
    txn_single(1'b0, 16'd0, 24'd6);
    txn_single(1'b1, 16'd500, 24'd3);
    txn_single(1'b0, 16'd1200, 24'd0);
    txn_abort(1'b1, 16'd4000, 24'd8, 3);
    txn_rstgap(1'b0, 16'd6000, 24'd4, 2);

    // abort wins over a request offered in the same IDLE cycle
    @(posedge clk); #1;
    abort = 1; req1_valid = 1; req1_period = 16'd3000; req1_dur = 24'd5;
    @(negedge clk);
    chk("abort_blocks_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clk); #1;
    abort = 0; req1_valid = 0;
    repeat (3) @(posedge clk);

    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 5);
      d    = $urandom_range(0, 24);
      case (kind)
        0: txn_single(1'b0, rnd_period(), 24'(d));
        1: txn_single(1'b1, rnd_period(), 24'(d));
        2: txn_both(rnd_period(), 24'(d), rnd_period(), 24'($urandom_range(0, 24)));
        3: begin
          d = $urandom_range(5, 24);
          txn_mid(rnd_period(), 24'(d), $urandom_range(2, d), rnd_period(),
                  24'($urandom_range(0, 24)));
        end
        4: begin
          d = $urandom_range(1, 12);
          c = $urandom_range(1, d);
          txn_abort(1'($urandom_range(0, 1)), rnd_period(), 24'(d), c);
        end
        default: txn_rstgap(1'($urandom_range(0, 1)), rnd_period(), 24'($urandom_range(1, 10)),
                            $urandom_range(1, GAP));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beep_arbiter.md
BEEP_ARBITER -- requirements
Module: beep_arbiter

Interface
REQ-001 Parameter GAP_CYC, default 24'd500_000, silent cycles inserted after every note.
REQ-002 Parameter MIN_PERIOD, default 16'd1000, smallest non-zero tone period forwarded.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0_valid, req1_valid  input  1 each  note offered by requester 0 (alarm) or 1 (melody).
REQ-007 req0_period, req1_period  input  16 each  tone period in clk cycles; 0 = rest.
REQ-008 req0_dur, req1_dur  input  24 each  note duration in clk cycles.
REQ-009 req0_ready, req1_ready  output  1 each  note-accept strobe.
REQ-010 abort  input  1  stop the current note immediately.
REQ-011 tone_en  output  1  enables the downstream PWM tone generator.
REQ-012 tone_period  output  16  period for the tone generator.
REQ-013 tone_duty  output  16  high time, always tone_period >> 1.
REQ-014 owner  output  1  index of the requester whose note is in play or gap.
REQ-015 busy  output  1  high in PLAY or GAP.
REQ-016 note_done  output  1  one-cycle pulse when a note's GAP completes normally.

Function
REQ-017 States: IDLE, PLAY, GAP. Only one state is active per cycle.
REQ-018 IDLE: if any reqN_valid, grant = 0 when req0_valid, else 1; assert reqN_ready for the granted requester for exactly that cycle; transfer occurs on valid&ready; next state PLAY.
REQ-019 Never assert both ready outputs in one cycle; ready is never asserted outside IDLE.
REQ-020 On transfer, latch period, dur and owner=grant; load a 24-bit counter with max(dur,1)-1.
REQ-021 Period clamp at latch: 0 stays 0 (rest); 1..MIN_PERIOD-1 becomes MIN_PERIOD; otherwise unchanged.
REQ-022 PLAY: tone_en = (latched period != 0); tone_period = latched period; counter decrements each cycle; at counter==0 go to GAP, loading the counter with GAP_CYC-1 (GAP_CYC==0: skip GAP, pulse note_done and go to IDLE).
REQ-023 Latency: tone_en rises the cycle after transfer; a note of dur D holds PLAY for exactly D cycles (D=0 behaves as 1).
REQ-024 GAP: tone_en=0; tone_period holds its value; at counter==0 pulse note_done, go to IDLE.
REQ-025 Preemption happens only at note boundaries: a melody note in PLAY is never cut by req0_valid; the next IDLE arbitration picks requester 0.
REQ-026 Back-to-back: IDLE lasts exactly one cycle when a request is pending, so the note-to-note pitch is D + GAP_CYC + 1 cycles.
REQ-027 abort (any state): next state IDLE, tone_en=0, no note_done, no ready in that cycle; abort dominates a simultaneous valid.
REQ-028 Input changes on period/dur while not in the transfer cycle have no effect.
REQ-029 busy = (state==PLAY || state==GAP); owner holds its value in IDLE.

Reset
REQ-030 rst high forces at the next edge: state IDLE, tone_en=0, tone_period=0, tone_duty=0, owner=0, busy=0, note_done=0, both ready=0, counter=0.
REQ-031 rst asserted mid-PLAY or mid-GAP discards the note with no note_done; rst dominates abort and all requests.

Verification (bench uses GAP_CYC=4, MIN_PERIOD=1000)
REQ-032 req1_valid, period=28400, dur=10 -> req1_ready pulses 1 cycle; tone_en=1, tone_period=28400, tone_duty=14200 for 10 cycles; 4 low cycles; note_done pulses; owner=1.
REQ-033 req0 and req1 valid in the same IDLE cycle -> req0_ready only, owner=0; req1 is served after req0's note_done plus 1 IDLE cycle.
REQ-034 req1 note dur=20 is playing; req0_valid rises at cycle 5 -> melody note completes all 20 cycles plus GAP; next grant goes to req0.
REQ-035 period=0, dur=6 -> busy=1 for 10 cycles, tone_en stays 0, note_done pulses; period=500 -> tone_period=1000, tone_duty=500; dur=0 -> one PLAY cycle.
REQ-036 abort at PLAY cycle 3 -> tone_en=0 next cycle, state IDLE, no note_done; rst mid-GAP -> all outputs at their reset values, no note_done.
